hazard_ctrl_unit: RTL and testbench

// Hazard/forwarding controller for the 5-stage 16-bit pipeline around the EX stage. Drives the

---
 rtl/hazard_ctrl_unit.sv | 182 ++++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_unit
//  Description : Hazard and forwarding controller for the EX stage of a
//                5-stage 16-bit pipeline.
//                - Forwarding selects for both ALU operands. EX/MEM has
//                  priority over MEM/WB, and r0 is never forwarded.
//                - Load-use bubbles, lasting LOAD_STALL_CYCLES cycles
//                  (legal range 1..3).
//                - Flush of IF/ID, ID/EX and EX/MEM when a branch resolved
//                  in MEM is taken.
//                - Full freeze while data memory is not ready. A branch
//                  seen during the freeze is remembered and acted on once
//                  the freeze ends.
//                - Saturating counters for bubbles and flushes.
//  Ports       : clock/reset     - rising-edge clock, sync active-high reset
//                id_*/ex_*/mem_*/wb_* - pipeline register/control taps
//                branch_taken    - taken branch sitting in MEM
//                ext_stall       - memory wait, freezes the pipeline
//                forward_a/b     - 00 regfile, 10 EX/MEM, 01 MEM/WB
//                pc_write, pc_src, ifid_write, ifid_flush, idex_bubble,
//                exmem_flush, pipe_write - pipeline register controls
//                stall_count, flush_count - saturating event counters
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl_unit #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       id_rs,
    input  logic [2:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [2:0]       ex_rs,
    input  logic [2:0]       ex_rt,
    input  logic [2:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [2:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [2:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic             branch_taken,
    input  logic             ext_stall,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic             pipe_write,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        LSTALL = 1'b1
    } state_t;

    // The first bubble is issued from RUN, so LSTALL covers the remaining ones.
    localparam logic [1:0] c_STALL_RELOAD = 2'(LOAD_STALL_CYCLES - 1);

    state_t           r_state;
    logic [1:0]       r_bcnt;
    logic             r_pendBr;
    logic [CNT_W-1:0] r_stallCount;
    logic [CNT_W-1:0] r_flushCount;

    logic w_loadUse;
    logic w_branch;
    logic w_doFlush;
    logic w_doStall;

    // ------------------------------------------------------------------
    // Forwarding selects
    // ------------------------------------------------------------------
    function automatic logic [1:0] fwdSel(input logic [2:0] src,
                                          input logic [2:0] memRd,
                                          input logic       memWr,
                                          input logic [2:0] wbRd,
                                          input logic       wbWr);
        if (memWr && (memRd != 3'd0) && (memRd == src))
            return 2'b10;
        else if (wbWr && (wbRd != 3'd0) && (wbRd == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        forward_a = 2'b00;
        forward_b = 2'b00;
        if (!reset) begin
            forward_a = fwdSel(ex_rs, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
            forward_b = fwdSel(ex_rt, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
        end
    end

    // ------------------------------------------------------------------
    // Hazard detection and priority: reset > freeze > branch > load-use
    // ------------------------------------------------------------------
    assign w_loadUse = ex_mem_read && ex_reg_write && (ex_rd != 3'd0) &&
                       ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    assign w_branch  = branch_taken || r_pendBr;
    assign w_doFlush = !reset && !ext_stall && w_branch;
    assign w_doStall = !reset && !ext_stall && !w_branch &&
                       ((r_state == LSTALL) || w_loadUse);

    // Mealy outputs: they react in the same cycle as the hazard.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        pipe_write  = 1'b1;
        pc_src      = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;
        if (reset) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_write = 1'b0;
        end else if (ext_stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_write = 1'b0;
        end else if (w_doFlush) begin
            pc_src      = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
        end else if (w_doStall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State, pending branch and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= RUN;
            r_bcnt       <= 2'd0;
            r_pendBr     <= 1'b0;
            r_stallCount <= '0;
            r_flushCount <= '0;
        end else if (ext_stall) begin
            // Frozen: only remember a branch that resolves while we wait.
            r_pendBr <= r_pendBr | branch_taken;
        end else if (w_branch) begin
            // A flush squashes the younger instruction, so any stall is void.
            r_pendBr <= 1'b0;
            r_state  <= RUN;
            r_bcnt   <= 2'd0;
            if (r_flushCount != '1)
                r_flushCount <= r_flushCount + 1'b1;
        end else if (r_state == LSTALL) begin
            if (r_stallCount != '1)
                r_stallCount <= r_stallCount + 1'b1;
            r_bcnt <= r_bcnt - 2'd1;
            if (r_bcnt == 2'd1)
                r_state <= RUN;
        end else if (w_loadUse) begin
            if (r_stallCount != '1)
                r_stallCount <= r_stallCount + 1'b1;
            if (c_STALL_RELOAD != 2'd0) begin
                r_bcnt  <= c_STALL_RELOAD;
                r_state <= LSTALL;
            end
        end
    end

    assign stall_count = r_stallCount;
    assign flush_count = r_flushCount;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl_unit
//  Description : Directed self-checking bench for hazard_ctrl_unit. It drives
//                two instances with the same stimulus: u1 uses single-cycle
//                stalls and 2-bit counters, and u3 uses 3-cycle stalls and
//                16-bit counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic       id_uses_rt, ex_mem_read, ex_reg_write, mem_reg_write;
    logic       wb_reg_write, branch_taken, ext_stall;

    logic [1:0]  w1FwdA, w1FwdB, w3FwdA, w3FwdB;
    logic        w1PcWrite, w1PcSrc, w1IfidWrite, w1IfidFlush, w1IdexBubble, w1ExmemFlush, w1PipeWrite;
    logic        w3PcWrite, w3PcSrc, w3IfidWrite, w3IfidFlush, w3IdexBubble, w3ExmemFlush, w3PipeWrite;
    logic [1:0]  w1Stall, w1Flush;
    logic [15:0] w3Stall, w3Flush;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clock = ~clock;

    hazard_ctrl_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(2)) u1 (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_reg_write(ex_reg_write), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .branch_taken(branch_taken),
        .ext_stall(ext_stall), .forward_a(w1FwdA), .forward_b(w1FwdB), .pc_write(w1PcWrite),
        .pc_src(w1PcSrc), .ifid_write(w1IfidWrite), .ifid_flush(w1IfidFlush),
        .idex_bubble(w1IdexBubble), .exmem_flush(w1ExmemFlush), .pipe_write(w1PipeWrite),
        .stall_count(w1Stall), .flush_count(w1Flush)
    );

    hazard_ctrl_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) u3 (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_reg_write(ex_reg_write), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .branch_taken(branch_taken),
        .ext_stall(ext_stall), .forward_a(w3FwdA), .forward_b(w3FwdB), .pc_write(w3PcWrite),
        .pc_src(w3PcSrc), .ifid_write(w3IfidWrite), .ifid_flush(w3IfidFlush),
        .idex_bubble(w3IdexBubble), .exmem_flush(w3ExmemFlush), .pipe_write(w3PipeWrite),
        .stall_count(w3Stall), .flush_count(w3Flush)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Move to the next cycle: inputs change 1 time unit after the rising edge.
    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic clearIn();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0;
        ex_mem_read = 0; ex_reg_write = 0; mem_rd = 0; mem_reg_write = 0;
        wb_rd = 0; wb_reg_write = 0; branch_taken = 0; ext_stall = 0;
    endtask

    // Load in EX writing r2 while the instruction in ID reads r2.
    task automatic loadHazard();
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 2; id_rs = 2;
    endtask

    initial begin
        // ---------------- reset cycle ----------------
        clearIn();
        reset = 1;
        ex_rs = 3; mem_rd = 3; mem_reg_write = 1;
        #2;
        chk("rst_pc_write",   32'(w1PcWrite), 0);
        chk("rst_ifid_write", 32'(w1IfidWrite), 0);
        chk("rst_pipe_write", 32'(w1PipeWrite), 0);
        chk("rst_fwd_a",      32'(w1FwdA), 0);
        nextCycle();
        nextCycle();
        reset = 0;
        clearIn();
        #1;
        chk("rst_stall_cnt",  32'(w3Stall), 0);
        chk("rst_flush_cnt",  32'(w3Flush), 0);
        chk("dflt_pc_write",  32'(w1PcWrite), 1);
        chk("dflt_pipe_write",32'(w1PipeWrite), 1);
        chk("dflt_bubble",    32'(w1IdexBubble), 0);

        // ---------------- forwarding ----------------
        ex_rs = 3; ex_rt = 3; mem_rd = 3; mem_reg_write = 1; wb_rd = 3; wb_reg_write = 1;
        #1;
        chk("fwd_a_mem",      32'(w1FwdA), 2'b10);
        chk("fwd_b_mem",      32'(w1FwdB), 2'b10);
        mem_reg_write = 0;
        #1;
        chk("fwd_a_wb",       32'(w1FwdA), 2'b01);
        ex_rs = 0; mem_rd = 0; wb_rd = 0; mem_reg_write = 1;
        #1;
        chk("fwd_a_r0",       32'(w1FwdA), 2'b00);
        ex_rt = 5; wb_rd = 5; mem_rd = 4;
        #1;
        chk("fwd_b_wb",       32'(w1FwdB), 2'b01);
        clearIn();

        // ---------------- load-use: 1 vs 3 bubbles ----------------
        nextCycle();
        loadHazard();
        #1;
        chk("lu1_pc_write",   32'(w1PcWrite), 0);
        chk("lu1_ifid_write", 32'(w1IfidWrite), 0);
        chk("lu1_bubble",     32'(w1IdexBubble), 1);
        chk("lu3_bubble0",    32'(w3IdexBubble), 1);
        nextCycle();
        clearIn();
        #1;
        chk("lu1_after_pcw",  32'(w1PcWrite), 1);
        chk("lu1_after_bub",  32'(w1IdexBubble), 0);
        chk("lu1_stall_cnt",  32'(w1Stall), 1);
        chk("lu3_bubble1",    32'(w3IdexBubble), 1);
        chk("lu3_pcw1",       32'(w3PcWrite), 0);
        nextCycle();
        chk("lu3_bubble2",    32'(w3IdexBubble), 1);
        nextCycle();
        chk("lu3_done_bub",   32'(w3IdexBubble), 0);
        chk("lu3_done_pcw",   32'(w3PcWrite), 1);
        chk("lu3_stall_cnt",  32'(w3Stall), 3);

        // ---------------- branch held across freeze ----------------
        nextCycle();
        branch_taken = 1; ext_stall = 1;
        #1;
        chk("frz_pc_write",   32'(w1PcWrite), 0);
        chk("frz_pipe_write", 32'(w1PipeWrite), 0);
        chk("frz_pc_src",     32'(w1PcSrc), 0);
        chk("frz_ifid_flush", 32'(w1IfidFlush), 0);
        chk("frz_exmem_flush",32'(w1ExmemFlush), 0);
        nextCycle();
        chk("frz2_ifid_write",32'(w1IfidWrite), 0);
        chk("frz2_pc_src",    32'(w1PcSrc), 0);
        chk("frz2_stall_cnt", 32'(w3Stall), 3);
        nextCycle();
        branch_taken = 0; ext_stall = 0;
        #1;
        chk("br_pc_src",      32'(w1PcSrc), 1);
        chk("br_ifid_flush",  32'(w1IfidFlush), 1);
        chk("br_bubble",      32'(w1IdexBubble), 1);
        chk("br_exmem_flush", 32'(w1ExmemFlush), 1);
        chk("br_pc_write",    32'(w1PcWrite), 1);
        chk("br_flush_pre",   32'(w1Flush), 0);
        nextCycle();
        chk("br_flush_cnt",   32'(w1Flush), 1);
        chk("br_flush_cnt3",  32'(w3Flush), 1);
        chk("br_cleared",     32'(w1PcSrc), 0);

        // ---------------- branch aborts a multi-cycle stall ----------------
        nextCycle();
        loadHazard();
        nextCycle();
        clearIn();
        branch_taken = 1;
        #1;
        chk("abort_pc_src",   32'(w3PcSrc), 1);
        chk("abort_flush",    32'(w3ExmemFlush), 1);
        chk("abort_pc_write", 32'(w3PcWrite), 1);
        chk("abort_ifid_w",   32'(w3IfidWrite), 1);
        nextCycle();
        branch_taken = 0;
        #1;
        chk("abort_no_bub",   32'(w3IdexBubble), 0);
        chk("abort_stall",    32'(w3Stall), 4);
        chk("abort_flushcnt", 32'(w3Flush), 2);

        // ---------------- reset in the middle of a stall ----------------
        nextCycle();
        loadHazard();
        nextCycle();
        clearIn();
        #1;
        chk("sat_pre_reset",  32'(w1Stall), 3);
        chk("mid_lstall_bub", 32'(w3IdexBubble), 1);
        reset = 1;
        #1;
        chk("rst2_bubble",    32'(w3IdexBubble), 0);
        chk("rst2_pc_write",  32'(w3PcWrite), 0);
        chk("rst2_pipe_w",    32'(w3PipeWrite), 0);
        chk("rst2_pc_src",    32'(w3PcSrc), 0);
        nextCycle();
        reset = 0;
        #1;
        chk("rst2_stall_cnt", 32'(w3Stall), 0);
        chk("rst2_flush_cnt", 32'(w3Flush), 0);
        chk("rst2_run_bub",   32'(w3IdexBubble), 0);
        chk("rst2_run_pcw",   32'(w3PcWrite), 1);

        // ---------------- counter saturation (2-bit) ----------------
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            loadHazard();
        end
        nextCycle();
        clearIn();
        #1;
        chk("sat_stall_cnt",  32'(w1Stall), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
